fhn_scheduler: RTL and testbench

FHN_SCHEDULER -- requirements
Module: fhn_scheduler

---
 rtl/fhn_pkg.sv | 7 +
 rtl/fhn_state_mem.sv | 50 +++++
 rtl/fhn_scheduler.sv | 100 ++++++++++
 tb/tb_fhn_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fhn_pkg.sv
// fhn_pkg: shared fixed-point types, widths and scheduler FSM states for the FHN neuron scheduler
package fhn_pkg;
  localparam int DATA_W = 16;
  localparam int FRC_BITS = 12;
  typedef logic signed [DATA_W-1:0] fx_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;
endpackage

// File: rtl/fhn_state_mem.sv
// fhn_state_mem: per-neuron v/w/stim register array; ports: state write (we,waddr,wv,ww), stim write (stim_we,stim_addr,stim_data), comb read (raddr->rv,rw,ri), registered read (rd_addr->rd_v,rd_w)
module fhn_state_mem import fhn_pkg::*; #(
  parameter int N = 8,
  parameter fx_t V_INIT = '0,
  parameter fx_t W_INIT = '0,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fx_t           wv,
  input  fx_t           ww,
  input  logic          stim_we,
  input  logic [AW-1:0] stim_addr,
  input  fx_t           stim_data,
  input  logic [AW-1:0] raddr,
  output fx_t           rv,
  output fx_t           rw,
  output fx_t           ri,
  input  logic [AW-1:0] rd_addr,
  output fx_t           rd_v,
  output fx_t           rd_w
);
  fx_t v_q [N];
  fx_t w_q [N];
  fx_t i_q [N];
  assign rv = v_q[raddr];
  assign rw = w_q[raddr];
  assign ri = i_q[raddr];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        v_q[k] <= V_INIT;
        w_q[k] <= W_INIT;
        i_q[k] <= '0;
      end
      rd_v <= '0;
      rd_w <= '0;
    end else begin
      if (we) begin
        v_q[waddr] <= wv;
        w_q[waddr] <= ww;
      end
      if (stim_we) i_q[stim_addr] <= stim_data;
      rd_v <= v_q[rd_addr];
      rd_w <= w_q[rd_addr];
    end
  end
endmodule

// File: rtl/fhn_scheduler.sv
// fhn_scheduler: time-multiplexes N_NEURONS FHN neurons over one external core; ports: start/busy/done/step_cnt control, stim write, rd readback, core_* operands/results, spike_valid/spike_id events
module fhn_scheduler import fhn_pkg::*; #(
  parameter int  N_NEURONS = 8,
  parameter int  CORE_LAT  = 1,
  parameter fx_t SPIKE_TH  = 16'sd2048,
  parameter fx_t V_INIT    = '0,
  parameter fx_t W_INIT    = '0,
  localparam int AW = $clog2(N_NEURONS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [31:0]   step_cnt,
  input  logic          stim_we,
  input  logic [AW-1:0] stim_addr,
  input  fx_t           stim_data,
  input  logic [AW-1:0] rd_addr,
  output fx_t           rd_v,
  output fx_t           rd_w,
  output fx_t           core_i,
  output fx_t           core_v,
  output fx_t           core_w,
  input  fx_t           core_v_nxt,
  input  fx_t           core_w_nxt,
  output logic          spike_valid,
  output logic [AW-1:0] spike_id
);
  state_t state;
  logic [AW-1:0] idx;
  logic [15:0] wcnt;
  fx_t mv, mw, mi, hv, hw, hi;
  fhn_state_mem #(.N(N_NEURONS), .V_INIT(V_INIT), .W_INIT(W_INIT)) u_mem (
    .clk,
    .rst,
    .we(state == WB),
    .waddr(idx),
    .wv(core_v_nxt),
    .ww(core_w_nxt),
    .stim_we,
    .stim_addr,
    .stim_data,
    .raddr(idx),
    .rv(mv),
    .rw(mw),
    .ri(mi),
    .rd_addr,
    .rd_v,
    .rd_w
  );
  assign busy = state != IDLE;
  always_comb begin
    core_v = state == IDLE ? '0 : state == ISSUE ? mv : hv;
    core_w = state == IDLE ? '0 : state == ISSUE ? mw : hw;
    core_i = state == IDLE ? '0 : state == ISSUE ? mi : hi;
    spike_valid = state == WB && hv < SPIKE_TH && core_v_nxt >= SPIKE_TH;
    spike_id = spike_valid ? idx : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      wcnt <= '0;
      done <= 1'b0;
      step_cnt <= '0;
      hv <= '0;
      hw <= '0;
      hi <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= ISSUE;
          idx <= '0;
        end
        ISSUE: begin
          hv <= mv;
          hw <= mw;
          hi <= mi;
          wcnt <= '0;
          state <= CORE_LAT == 0 ? WB : WAIT;
        end
        WAIT: begin
          wcnt <= wcnt + 16'd1;
          if (wcnt == 16'(CORE_LAT - 1)) state <= WB;
        end
        WB: if (idx == AW'(N_NEURONS - 1)) begin
          state <= IDLE;
          idx <= '0;
          done <= 1'b1;
          step_cnt <= step_cnt + 32'd1;
        end else begin
          state <= ISSUE;
          idx <= idx + AW'(1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fhn_scheduler.sv
// tb_fhn_scheduler: directed self-checking bench for fhn_scheduler with a stub FHN core
module tb_fhn_scheduler;
  import fhn_pkg::*;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, stim_we = 1'b0;
  logic [2:0] stim_addr = '0, rd_addr = '0;
  fx_t stim_data = '0;
  logic busy, done, spike_valid;
  logic [31:0] step_cnt;
  logic [2:0] spike_id;
  fx_t rd_v, rd_w, core_i, core_v, core_w, core_v_nxt, core_w_nxt;
  int mode = 0, nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  assign core_v_nxt = mode == 1 ? core_i : fx_t'(core_v + 16'sd1);
  assign core_w_nxt = mode == 1 ? core_w : fx_t'(core_w - 16'sd1);
  fhn_scheduler dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .step_cnt(step_cnt),
    .stim_we(stim_we),
    .stim_addr(stim_addr),
    .stim_data(stim_data),
    .rd_addr(rd_addr),
    .rd_v(rd_v),
    .rd_w(rd_w),
    .core_i(core_i),
    .core_v(core_v),
    .core_w(core_w),
    .core_v_nxt(core_v_nxt),
    .core_w_nxt(core_w_nxt),
    .spike_valid(spike_valid),
    .spike_id(spike_id)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    start = 1'b0;
    stim_we = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask
  task automatic rd(input int a, output fx_t v, output fx_t w);
    rd_addr = 3'(a);
    tick;
    v = rd_v;
    w = rd_w;
  endtask
  task automatic write_stim(input int a, input fx_t d);
    stim_we = 1'b1;
    stim_addr = 3'(a);
    stim_data = d;
    tick;
    stim_we = 1'b0;
  endtask
  task automatic run_sweep(output int cyc, output int nspk, output int sid, output bit bok);
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    nspk = 0;
    sid = -1;
    bok = 1'b1;
    while (!done && cyc < 200) begin
      if (!busy) bok = 1'b0;
      if (spike_valid) begin
        nspk++;
        sid = int'(spike_id);
      end
      tick;
      cyc++;
    end
  endtask
  task automatic test_reset;
    fx_t v, w;
    do_reset;
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0 || spike_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ctrl: busy=%b done=%b spike=%b, want 0 0 0", busy, done, spike_valid);
    end
    nvec++;
    if (step_cnt !== 32'd0) begin
      nerr++;
      $display("FAIL reset_step_cnt: got %0d want 0", step_cnt);
    end
    nvec++;
    if (core_v !== 16'sd0 || core_w !== 16'sd0 || core_i !== 16'sd0) begin
      nerr++;
      $display("FAIL reset_core: v=%0d w=%0d i=%0d want 0 0 0", core_v, core_w, core_i);
    end
    for (int a = 0; a < 8; a++) begin
      rd(a, v, w);
      nvec++;
      if (v !== 16'sd0 || w !== 16'sd0) begin
        nerr++;
        $display("FAIL reset_rd[%0d]: got v=%0d w=%0d want 0 0", a, v, w);
      end
    end
  endtask
  task automatic test_timing;
    int cyc, nspk, sid;
    bit bok;
    fx_t v, w;
    do_reset;
    mode = 0;
    run_sweep(cyc, nspk, sid, bok);
    nvec++;
    if (cyc !== 25) begin
      nerr++;
      $display("FAIL timing_done: done at cycle %0d want 25", cyc);
    end
    nvec++;
    if (!bok || busy !== 1'b0) begin
      nerr++;
      $display("FAIL timing_busy: busy_during=%b busy_at_done=%b want 1 0", bok, busy);
    end
    nvec++;
    if (step_cnt !== 32'd1) begin
      nerr++;
      $display("FAIL timing_step_cnt: got %0d want 1", step_cnt);
    end
    tick;
    nvec++;
    if (done !== 1'b0 || core_v !== 16'sd0) begin
      nerr++;
      $display("FAIL timing_idle: done=%b core_v=%0d want 0 0", done, core_v);
    end
    for (int a = 0; a < 8; a++) begin
      rd(a, v, w);
      nvec++;
      if (v !== 16'sd1 || w !== -16'sd1) begin
        nerr++;
        $display("FAIL timing_rd[%0d]: got v=%0d w=%0d want 1 -1", a, v, w);
      end
    end
  endtask
  task automatic test_start_ignored;
    int ndone, first;
    fx_t v, w;
    do_reset;
    mode = 0;
    ndone = 0;
    first = 0;
    start = 1'b1;
    tick;
    for (int c = 1; c <= 60; c++) begin
      start = c == 3 || c == 10;
      if (done) begin
        ndone++;
        if (first == 0) first = c;
      end
      tick;
    end
    start = 1'b0;
    nvec++;
    if (ndone !== 1 || first !== 25) begin
      nerr++;
      $display("FAIL ignore_start: %0d done pulses first at %0d, want 1 at 25", ndone, first);
    end
    nvec++;
    if (step_cnt !== 32'd1) begin
      nerr++;
      $display("FAIL ignore_step_cnt: got %0d want 1", step_cnt);
    end
    rd(4, v, w);
    nvec++;
    if (v !== 16'sd1) begin
      nerr++;
      $display("FAIL ignore_rd4: got v=%0d want 1", v);
    end
  endtask
  task automatic test_spike;
    int cyc, nspk, sid;
    bit bok;
    fx_t v, w;
    do_reset;
    mode = 1;
    write_stim(5, 16'sd2048);
    write_stim(2, 16'sd2047);
    write_stim(3, -16'sd1);
    run_sweep(cyc, nspk, sid, bok);
    nvec++;
    if (nspk !== 1 || sid !== 5) begin
      nerr++;
      $display("FAIL spike_sweep1: %0d spikes last id %0d, want 1 id 5", nspk, sid);
    end
    rd(5, v, w);
    nvec++;
    if (v !== 16'sd2048) begin
      nerr++;
      $display("FAIL spike_rd5: got %0d want 2048", v);
    end
    rd(2, v, w);
    nvec++;
    if (v !== 16'sd2047) begin
      nerr++;
      $display("FAIL spike_rd2: got %0d want 2047", v);
    end
    rd(3, v, w);
    nvec++;
    if (v !== -16'sd1) begin
      nerr++;
      $display("FAIL spike_rd3: got %0d want -1", v);
    end
    write_stim(2, 16'sd2048);
    run_sweep(cyc, nspk, sid, bok);
    nvec++;
    if (nspk !== 1 || sid !== 2) begin
      nerr++;
      $display("FAIL spike_sweep2: %0d spikes last id %0d, want 1 id 2", nspk, sid);
    end
  endtask
  task automatic test_stim_timing;
    int c, cyc, nspk, sid;
    bit bok;
    fx_t v, w;
    do_reset;
    mode = 1;
    write_stim(0, 16'sd1000);
    write_stim(1, 16'sd500);
    start = 1'b1;
    tick;
    start = 1'b0;
    c = 1;
    while (!done && c < 200) begin
      stim_we = c == 2 || c == 4;
      stim_addr = c == 2 ? 3'd0 : 3'd1;
      stim_data = c == 2 ? 16'sd4096 : 16'sd700;
      if (c == 2) begin
        nvec++;
        if (core_i !== 16'sd1000) begin
          nerr++;
          $display("FAIL stim_hold: core_i=%0d in WAIT want 1000", core_i);
        end
      end
      if (c == 4) begin
        nvec++;
        if (core_i !== 16'sd500) begin
          nerr++;
          $display("FAIL stim_issue: core_i=%0d in ISSUE want 500", core_i);
        end
      end
      tick;
      c++;
    end
    stim_we = 1'b0;
    nvec++;
    if (c !== 25) begin
      nerr++;
      $display("FAIL stim_done: done at cycle %0d want 25", c);
    end
    rd(0, v, w);
    nvec++;
    if (v !== 16'sd1000) begin
      nerr++;
      $display("FAIL stim_rd0_s1: got %0d want 1000", v);
    end
    rd(1, v, w);
    nvec++;
    if (v !== 16'sd500) begin
      nerr++;
      $display("FAIL stim_rd1_s1: got %0d want 500", v);
    end
    run_sweep(cyc, nspk, sid, bok);
    rd(0, v, w);
    nvec++;
    if (v !== 16'sd4096) begin
      nerr++;
      $display("FAIL stim_rd0_s2: got %0d want 4096", v);
    end
    rd(1, v, w);
    nvec++;
    if (v !== 16'sd700) begin
      nerr++;
      $display("FAIL stim_rd1_s2: got %0d want 700", v);
    end
  endtask
  task automatic test_rst_mid;
    int cyc, nspk, sid, ndone;
    bit bok;
    fx_t v, w;
    do_reset;
    mode = 0;
    run_sweep(cyc, nspk, sid, bok);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (11) tick;
    nvec++;
    if (busy !== 1'b1 || core_v !== 16'sd1) begin
      nerr++;
      $display("FAIL rstmid_pre: busy=%b core_v=%0d want 1 1", busy, core_v);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      tick;
    end
    nvec++;
    if (ndone !== 0 || busy !== 1'b0 || step_cnt !== 32'd0) begin
      nerr++;
      $display("FAIL rstmid_abort: done=%0d busy=%b step_cnt=%0d want 0 0 0", ndone, busy, step_cnt);
    end
    for (int a = 0; a < 8; a++) begin
      rd(a, v, w);
      nvec++;
      if (v !== 16'sd0 || w !== 16'sd0) begin
        nerr++;
        $display("FAIL rstmid_rd[%0d]: got v=%0d w=%0d want 0 0", a, v, w);
      end
    end
    run_sweep(cyc, nspk, sid, bok);
    nvec++;
    if (cyc !== 25 || step_cnt !== 32'd1) begin
      nerr++;
      $display("FAIL rstmid_resume: done at %0d step_cnt=%0d want 25 1", cyc, step_cnt);
    end
    rd(3, v, w);
    nvec++;
    if (v !== 16'sd1) begin
      nerr++;
      $display("FAIL rstmid_rd3: got %0d want 1", v);
    end
  endtask
  initial begin
    test_reset;
    test_timing;
    test_start_ignored;
    test_spike;
    test_stim_timing;
    test_rst_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
